// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: lives, level, READY banner and freeze control for the HUD and sprites.
// Optional macro READY_BLINK_EN makes the READY banner blink every 8 frames.
//
// state       | meaning
// ATTRACT     | idle after reset, waiting for start_btn
// READY       | READY banner shown, play frozen for READY_FRAMES ticks
// PLAY        | gameplay running
// DEATH       | Pac-Man caught, frozen for DEATH_FRAMES ticks
// CLEAR       | maze cleared, frozen for CLEAR_FRAMES ticks
// GAME_OVER   | no lives left, waiting for a fresh start_btn press
module game_flow_ctrl #(
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90,
    parameter int CLEAR_FRAMES = 60,
    parameter int LIVES_INIT   = 3,
    parameter int MAX_LEVEL    = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pacman_caught,
    input  logic       dots_cleared,
    output logic [1:0] pacman_lifes,
    output logic       waiting,
    output logic [3:0] level,
    output logic       freeze,
    output logic       game_over,
    output logic       entities_reset,
    output logic       maze_reload
);

    typedef enum logic [2:0] {
        S_ATTRACT   = 3'd0,
        S_READY     = 3'd1,
        S_PLAY      = 3'd2,
        S_DEATH     = 3'd3,
        S_CLEAR     = 3'd4,
        S_GAME_OVER = 3'd5
    } state_t;

    localparam logic [7:0] READY_N = 8'(READY_FRAMES);
    localparam logic [7:0] DEATH_N = 8'(DEATH_FRAMES);
    localparam logic [7:0] CLEAR_N = 8'(CLEAR_FRAMES);
    localparam logic [1:0] LIVES_N = 2'(LIVES_INIT);
    localparam logic [3:0] MAX_LVL = 4'(MAX_LEVEL);

    state_t     state_q, state_d;
    logic [7:0] fcnt_q, fcnt_d, fcnt_nxt;
    logic [1:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic       start_prev_q;
    logic       new_game;
    logic       waiting_q, waiting_d;
    logic       freeze_q, freeze_d;
    logic       game_over_q, game_over_d;
    logic       ent_rst_q, ent_rst_d;
    logic       maze_rld_q, maze_rld_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_ATTRACT;
            fcnt_q       <= 8'd0;
            lives_q      <= 2'd0;
            level_q      <= 4'd1;
            start_prev_q <= 1'b0;
            waiting_q    <= 1'b0;
            freeze_q     <= 1'b1;
            game_over_q  <= 1'b0;
            ent_rst_q    <= 1'b0;
            maze_rld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            start_prev_q <= start_btn;
            waiting_q    <= waiting_d;
            freeze_q     <= freeze_d;
            game_over_q  <= game_over_d;
            ent_rst_q    <= ent_rst_d;
            maze_rld_q   <= maze_rld_d;
        end
    end

    // Timed states leave on the tick that brings the counter up to the limit.
    always_comb begin
        fcnt_nxt   = fcnt_q + 8'd1;
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        ent_rst_d  = 1'b0;
        maze_rld_d = 1'b0;
        new_game   = 1'b0;
        case (state_q)
            S_ATTRACT: new_game = start_btn;
            S_READY: begin
                if (frame_tick && fcnt_nxt == READY_N) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (pacman_caught)     state_d = S_DEATH;
                else if (dots_cleared) state_d = S_CLEAR;
            end
            S_DEATH: begin
                if (frame_tick && fcnt_nxt == DEATH_N) begin
                    if (lives_q == 2'd0) begin
                        state_d = S_GAME_OVER;
                    end else begin
                        lives_d   = lives_q - 2'd1;
                        ent_rst_d = 1'b1;
                        state_d   = S_READY;
                    end
                end
            end
            S_CLEAR: begin
                if (frame_tick && fcnt_nxt == CLEAR_N) begin
                    level_d    = (level_q >= MAX_LVL) ? MAX_LVL : level_q + 4'd1;
                    ent_rst_d  = 1'b1;
                    maze_rld_d = 1'b1;
                    state_d    = S_READY;
                end
            end
            S_GAME_OVER: new_game = start_btn && !start_prev_q;
            default: state_d = S_ATTRACT;
        endcase
        if (new_game) begin
            state_d    = S_READY;
            lives_d    = LIVES_N;
            level_d    = 4'd1;
            ent_rst_d  = 1'b1;
            maze_rld_d = 1'b1;
        end
        if (state_d != state_q) fcnt_d = 8'd0;
        else if (frame_tick)    fcnt_d = fcnt_nxt;
        else                    fcnt_d = fcnt_q;
    end

    // Outputs are derived from the upcoming state so they register alongside it.
    always_comb begin
        freeze_d    = (state_d != S_PLAY);
        game_over_d = (state_d == S_GAME_OVER);
`ifdef READY_BLINK_EN
        waiting_d   = (state_d == S_READY) && !fcnt_d[3];
`else
        waiting_d   = (state_d == S_READY);
`endif
    end

    assign pacman_lifes   = lives_q;
    assign level          = level_q;
    assign waiting        = waiting_q;
    assign freeze         = freeze_q;
    assign game_over      = game_over_q;
    assign entities_reset = ent_rst_q;
    assign maze_reload    = maze_rld_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Testbench for game_flow_ctrl: directed sequence plus random traffic,
// compared every cycle against a phase/tick-count reference model.
module tb_game_flow_ctrl;

    localparam int RF = 120;
    localparam int DF = 90;
    localparam int CF = 60;
    localparam int LI = 3;
    localparam int ML = 15;

    localparam int M_ATTRACT = 0;
    localparam int M_READY   = 1;
    localparam int M_PLAY    = 2;
    localparam int M_DEATH   = 3;
    localparam int M_CLEAR   = 4;
    localparam int M_GOVER   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       pacman_caught = 1'b0;
    logic       dots_cleared = 1'b0;
    logic [1:0] pacman_lifes;
    logic       waiting;
    logic [3:0] level;
    logic       freeze;
    logic       game_over;
    logic       entities_reset;
    logic       maze_reload;

    int checks = 0;
    int failures = 0;

    int m_ph = M_ATTRACT;
    int m_t = 0;
    int m_lives = 0;
    int m_level = 1;
    bit m_sprev = 1'b0;
    bit m_er = 1'b0;
    bit m_mr = 1'b0;

    game_flow_ctrl #(
        .READY_FRAMES(RF), .DEATH_FRAMES(DF), .CLEAR_FRAMES(CF),
        .LIVES_INIT(LI), .MAX_LEVEL(ML)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .pacman_caught(pacman_caught), .dots_cleared(dots_cleared),
        .pacman_lifes(pacman_lifes), .waiting(waiting), .level(level),
        .freeze(freeze), .game_over(game_over), .entities_reset(entities_reset),
        .maze_reload(maze_reload)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rs, input bit ft, input bit sb, input bit pc, input bit dc);
        int nph;
        bit ng;
        m_er = 1'b0;
        m_mr = 1'b0;
        if (rs) begin
            m_ph = M_ATTRACT; m_t = 0; m_lives = 0; m_level = 1; m_sprev = 1'b0;
            return;
        end
        nph = m_ph;
        ng = 1'b0;
        if (ft) m_t = (m_t + 1) % 256;
        case (m_ph)
            M_ATTRACT: ng = sb;
            M_READY:   if (ft && m_t == RF) nph = M_PLAY;
            M_PLAY:    if (pc) nph = M_DEATH; else if (dc) nph = M_CLEAR;
            M_DEATH: if (ft && m_t == DF) begin
                if (m_lives == 0) nph = M_GOVER;
                else begin m_lives = m_lives - 1; m_er = 1'b1; nph = M_READY; end
            end
            M_CLEAR: if (ft && m_t == CF) begin
                m_level = (m_level + 1 > ML) ? ML : m_level + 1;
                m_er = 1'b1; m_mr = 1'b1; nph = M_READY;
            end
            default: ng = sb && !m_sprev;
        endcase
        if (ng) begin
            nph = M_READY; m_lives = LI; m_level = 1; m_er = 1'b1; m_mr = 1'b1;
        end
        if (nph != m_ph) m_t = 0;
        m_ph = nph;
        m_sprev = sb;
    endtask

    function automatic int exp_waiting();
        if (m_ph != M_READY) return 0;
`ifdef READY_BLINK_EN
        return ((m_t / 8) % 2 == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic check_all();
        chk("lives", int'(pacman_lifes), m_lives);
        chk("level", int'(level), m_level);
        chk("waiting", int'(waiting), exp_waiting());
        chk("freeze", int'(freeze), (m_ph != M_PLAY) ? 1 : 0);
        chk("game_over", int'(game_over), (m_ph == M_GOVER) ? 1 : 0);
        chk("entities_reset", int'(entities_reset), int'(m_er));
        chk("maze_reload", int'(maze_reload), int'(m_mr));
    endtask

    task automatic cyc(input bit rs, input bit ft, input bit sb, input bit pc, input bit dc);
        reset = rs; frame_tick = ft; start_btn = sb; pacman_caught = pc; dots_cleared = dc;
        @(posedge clk);
        #1;
        model_step(rs, ft, sb, pc, dc);
        check_all();
    endtask

    task automatic run_until(input string tag, input int target, input int max_cyc, input bit sb);
        int n;
        n = 0;
        while (m_ph != target && n < max_cyc) begin
            cyc(1'b0, 1'($urandom_range(0, 1)), sb, 1'b0, 1'b0);
            n++;
        end
        chk({tag, "_reached"}, m_ph, target);
    endtask

    initial begin
        // reset state
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_freeze", int'(freeze), 1);
        chk("rst_level", int'(level), 1);
        chk("rst_lives", int'(pacman_lifes), 0);
        repeat (5) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);

        // start from attract
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_lives", int'(pacman_lifes), 3);
        chk("start_waiting", int'(waiting), 1);
        chk("start_pulses", int'({entities_reset, maze_reload}), 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pulse_once", int'({entities_reset, maze_reload}), 0);
        run_until("ready1", M_PLAY, 2000, 1'b0);
        chk("play_freeze", int'(freeze), 0);

        // caught, with a concurrent frame tick
        repeat (7) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("death_freeze", int'(freeze), 1);
        run_until("death1", M_READY, 2000, 1'b0);
        chk("death1_lives", int'(pacman_lifes), 2);
        chk("death1_er", int'({entities_reset, maze_reload}), 2);
        run_until("ready2", M_PLAY, 2000, 1'b0);

        // caught and cleared together: caught wins
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_until("death2", M_READY, 2000, 1'b0);
        chk("both_level", int'(level), 1);
        run_until("ready3", M_PLAY, 2000, 1'b0);

        // clear the maze
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_until("clear1", M_READY, 2000, 1'b0);
        chk("clear_level", int'(level), 2);
        chk("clear_mr", int'(maze_reload), 1);
        run_until("ready4", M_PLAY, 2000, 1'b0);

        // two more deaths with the button held -> game over, no restart
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_until("death3", M_READY, 2000, 1'b1);
        run_until("ready5", M_PLAY, 2000, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_until("death4", M_GOVER, 2000, 1'b1);
        chk("go_flag", int'(game_over), 1);
        chk("go_lives", int'(pacman_lifes), 0);
        repeat (10) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
        chk("go_held", int'(game_over), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("restart_lives", int'(pacman_lifes), 3);
        chk("restart_level", int'(level), 1);
        chk("restart_waiting", int'(waiting), 1);

        // clear 16 levels: saturate at MAX_LEVEL
        for (int i = 0; i < 16; i++) begin
            run_until("lvl_play", M_PLAY, 2000, 1'b0);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
            run_until("lvl_ready", M_READY, 2000, 1'b0);
        end
        chk("level_sat", int'(level), 15);

        // reset in the middle of DEATH
        run_until("pre_rst", M_PLAY, 2000, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (20) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("midrst_state", int'({waiting, freeze, game_over, entities_reset, maze_reload}), 8);
        chk("midrst_lvl", int'({pacman_lifes, level}), 1);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            cyc(1'($urandom_range(0, 1999) == 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 40) == 0),
                1'($urandom_range(0, 60) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
